// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame size, default bit
// timing, FSM state encoding and the 3-sample majority vote.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 434;  // 50 MHz / 115200 baud

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // Two-out-of-three majority, used to reject single-sample noise.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Serial input and received-byte outputs of the UART receiver.
// master = line driver / byte consumer, slave = the receiver itself.
interface uart_rx_core_if;
  import uart_pkg::*;

  logic                 rx_serial;
  logic [DATA_BITS-1:0] RxData;
  logic                 RxDone;
  logic                 FrameErr;

  modport master (output rx_serial, input RxData, input RxDone, input FrameErr);
  modport slave  (input rx_serial, output RxData, output RxDone, output FrameErr);

endinterface

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for the asynchronous serial line. Resets to 1 so an
// idle (high) line never looks like a start bit coming out of reset.
module uart_bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the raw line through two flops to settle metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver, 8N1, LSB first. Each bit is decided by a majority vote of
// three samples around the bit centre. Good bytes appear on RxData with a
// one-cycle RxDone; a low stop bit gives a one-cycle FrameErr and the byte
// is dropped. The stop state exits at mid-stop-bit so frames sent with no
// idle gap are still caught.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_core_if.slave  bus
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(HALF_BIT + 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic                 rxs;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 s0_q, s1_q;
  logic                 vote, at_vote, at_last;

  uart_bit_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.rx_serial),
    .q_o   (rxs)
  );

  assign at_vote = (cnt_q == CNT_VOTE);
  assign at_last = (cnt_q == CNT_LAST);
  // Third sample is the live synchronised bit at the vote point.
  assign vote    = maj3(s0_q, s1_q, rxs);

  // Capture the two samples that precede the vote point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      if (cnt_q == CNT_S0) s0_q <= rxs;
      if (cnt_q == CNT_S1) s1_q <= rxs;
    end
  end

  // Next-state logic: bit timer, bit index, shift register and output pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = at_last ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Timer held at zero so START is entered with a clean count.
        cnt_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (at_vote && vote) begin
          state_d = ST_IDLE;          // glitch, not a real start bit
          cnt_d   = '0;
        end else if (at_last) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (at_vote) shift_d[idx_q] = vote;
        if (at_last) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = ST_STOP;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (at_vote) begin
          cnt_d = '0;
          if (vote) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // A held-low line reports one framing error, then waits for idle.
        cnt_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.RxData   = data_q;
  assign bus.RxDone   = done_q;
  assign bus.FrameErr = ferr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit: table of frames plus
// hand sequences for glitch, break, back-to-back and mid-frame reset.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int LAT = 9*CPB + CPB/2 + 1 + 3;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_done;
    int         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_rx_core_if bus ();

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int done_cnt = 0;
  int fe_cnt = 0;
  int done_cyc = 0;
  int both_cnt = 0;
  logic [7:0] rx_log [64];
  always @(negedge clk) begin
    if (bus.RxDone) begin
      rx_log[done_cnt[5:0]] <= bus.RxData;
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.FrameErr) fe_cnt <= fe_cnt + 1;
    if (bus.RxDone && bus.FrameErr) both_cnt <= both_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic bit_out(input logic v);
    bus.rx_serial = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(stop);
    bus.rx_serial = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.rx_serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs [6];
  int d0, f0, base;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
    vecs[4] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vecs[5] = '{8'hC3, 1'b1, 1, 0, 8'hC3};

    // Reset state, then a quiet idle line.
    bus.rx_serial = 1'b1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_data", int'(bus.RxData), 0);
    chk("rst_done", int'(bus.RxDone), 0);
    chk("rst_ferr", int'(bus.FrameErr), 0);
    reset = 1'b0;
    idle(200);
    chk("idle_done_cnt", done_cnt, 0);
    chk("idle_fe_cnt", fe_cnt, 0);
    chk("idle_data", int'(bus.RxData), 0);

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt;
      f0 = fe_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      idle(2*CPB);
      chk($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_done);
      chk($sformatf("vec%0d_ferr", v), fe_cnt - f0, vecs[v].exp_fe);
      chk($sformatf("vec%0d_data", v), int'(bus.RxData), int'(vecs[v].exp_data));
      if (vecs[v].exp_done == 1)
        chk_rng($sformatf("vec%0d_latency", v), done_cyc - start_cyc, LAT - 2, LAT + 2);
    end

    // Short low glitch on an idle line is rejected.
    d0 = done_cnt;
    f0 = fe_cnt;
    bus.rx_serial = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(2*CPB);
    chk("glitch_done", done_cnt - d0, 0);
    chk("glitch_ferr", fe_cnt - f0, 0);
    chk("glitch_state", int'(dut.state_q), int'(ST_IDLE));

    // Good A5, then bad stop followed by a long break: one FrameErr only.
    send_frame(8'hA5, 1'b1);
    idle(2*CPB);
    chk("pre_break_data", int'(bus.RxData), 8'hA5);
    d0 = done_cnt;
    f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    bus.rx_serial = 1'b0;
    for (int i = 0; i < 20; i++) bit_out(1'b0);
    idle(3*CPB);
    chk("break_ferr", fe_cnt - f0, 1);
    chk("break_done", done_cnt - d0, 0);
    chk("break_data", int'(bus.RxData), 8'hA5);
    chk("break_state", int'(dut.state_q), int'(ST_IDLE));

    // Back-to-back frames with no idle gap.
    d0 = done_cnt;
    base = done_cnt;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(2*CPB);
    chk("b2b_done", done_cnt - d0, 2);
    chk("b2b_first", int'(rx_log[base[5:0]]), 8'h12);
    chk("b2b_second", int'(rx_log[6'(base + 1)]), 8'h34);
    chk("b2b_word", int'({rx_log[base[5:0]], rx_log[6'(base + 1)]}), 16'h1234);
    chk_rng("b2b_latency", done_cyc - start_cyc, LAT - 2, LAT + 2);

    // Reset in the middle of data bit 4 aborts the frame cleanly.
    d0 = done_cnt;
    f0 = fe_cnt;
    begin
      logic [7:0] ab;
      ab = 8'h5F;
      bit_out(1'b0);
      for (int i = 0; i < 4; i++) bit_out(ab[i]);
      bus.rx_serial = ab[4];
      repeat (CPB/2) @(posedge clk);
      #1;
      reset = 1'b1;
      bus.rx_serial = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
    end
    idle(2*CPB);
    chk("abort_done", done_cnt - d0, 0);
    chk("abort_ferr", fe_cnt - f0, 0);
    chk("abort_data", int'(bus.RxData), 0);
    send_frame(8'h81, 1'b1);
    idle(2*CPB);
    chk("post_abort_done", done_cnt - d0, 1);
    chk("post_abort_data", int'(bus.RxData), 8'h81);
    chk("post_abort_ferr", fe_cnt - f0, 0);

    chk("pulse_exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
